// File: rtl/mult8x8_seq.sv
// mult8x8_seq: sequential 8x8 unsigned multiplier, one 4x4 partial product per clock.
// Rev 1.0
`default_nettype none

module mult4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    assign p = {4'b0000, a} * {4'b0000, b};
endmodule

module mult8x8_seq (
    input  logic        clk,
    input  logic        reset_a,
    input  logic        start,
    input  logic [7:0]  dataa,
    input  logic [7:0]  datab,
    output logic [15:0] product,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PP0  = 3'd1,
        PP1  = 3'd2,
        PP2  = 3'd3,
        PP3  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  a_reg;
    logic [7:0]  b_reg;
    logic [15:0] acc;
    logic [3:0]  a_nib;
    logic [3:0]  b_nib;
    logic [7:0]  pp;
    logic [15:0] pp_shifted;
    logic [15:0] sum;

    // Nibble steering: PP1/PP3 use the high multiplicand nibble, PP2/PP3 the high multiplier nibble.
    always_comb begin
        a_nib = ((state == PP1) || (state == PP3)) ? a_reg[7:4] : a_reg[3:0];
        b_nib = ((state == PP2) || (state == PP3)) ? b_reg[7:4] : b_reg[3:0];
    end

    mult4x4 u_mult4x4 (
        .a (a_nib),
        .b (b_nib),
        .p (pp)
    );

    always_comb begin
        pp_shifted = {8'h00, pp};
        case (state)
            PP1, PP2: pp_shifted = {4'h0, pp, 4'h0};
            PP3:      pp_shifted = {pp, 8'h00};
            default:  pp_shifted = {8'h00, pp};
        endcase
        sum = acc + pp_shifted;
    end

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? PP0 : IDLE;
            PP0:     state_next = PP1;
            PP1:     state_next = PP2;
            PP2:     state_next = PP3;
            PP3:     state_next = DONE;
            DONE:    state_next = start ? PP0 : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            a_reg   <= 8'h00;
            b_reg   <= 8'h00;
            acc     <= 16'h0000;
            product <= 16'h0000;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg <= dataa;
                        b_reg <= datab;
                        acc   <= 16'h0000;
                    end
                end
                PP0, PP1, PP2: acc <= sum;
                // Final partial product goes straight to the output register.
                PP3:           product <= sum;
                default: ;
            endcase
        end
    end

    assign busy = (state == PP0) || (state == PP1) || (state == PP2) || (state == PP3);
    assign done = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_mult8x8_seq.sv
// tb_mult8x8_seq: directed and randomised self-checking bench for mult8x8_seq.
// Rev 1.0
`default_nettype none

module tb_mult8x8_seq;
    logic        clk;
    logic        reset_a;
    logic        start;
    logic [7:0]  dataa;
    logic [7:0]  datab;
    logic [15:0] product;
    logic        busy;
    logic        done;

    int          n_cmp;
    int          n_bad;
    logic [15:0] last_prod;

    mult8x8_seq dut (
        .clk     (clk),
        .reset_a (reset_a),
        .start   (start),
        .dataa   (dataa),
        .datab   (datab),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full multiply with start pulsed for a single cycle; operands scrambled after acceptance.
    task automatic run_mult(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        int n;
        @(negedge clk);
        start = 1'b1; dataa = a; datab = b;
        @(negedge clk);
        start = 1'b0; dataa = ~a; datab = ~b;
        check_val("busy_pp0", {31'd0, busy}, 32'd1);
        check_val("done_pp0", {31'd0, done}, 32'd0);
        n = 1;
        while (done !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
            if (n == 4) check_val("hold_pp3", {16'd0, product}, {16'd0, last_prod});
        end
        check_val("latency", n, 5);
        check_val("product", {16'd0, product}, {16'd0, exp});
        check_val("busy_done", {31'd0, busy}, 32'd0);
        last_prod = exp;
    endtask

    initial begin
        int n;
        int dcnt;
        logic [7:0] ra;
        logic [7:0] rb;
        n_cmp = 0; n_bad = 0; last_prod = 16'h0000;
        reset_a = 1'b1; start = 1'b0; dataa = 8'h00; datab = 8'h00;
        #2;
        check_val("rst_product", {16'd0, product}, 32'h0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_a = 1'b0;

        run_mult(8'h12, 8'h34, 16'h03A8);
        run_mult(8'hFF, 8'hFF, 16'hFE01);
        run_mult(8'hA5, 8'h5A, 16'h3A02);
        run_mult(8'h00, 8'hC7, 16'h0000);
        run_mult(8'h0F, 8'h01, 16'h000F);
        run_mult(8'h80, 8'h02, 16'h0100);

        // Start during busy is ignored.
        @(negedge clk);
        start = 1'b1; dataa = 8'h12; datab = 8'h34;
        @(negedge clk);
        start = 1'b1; dataa = 8'hFF; datab = 8'hFF;
        @(negedge clk);
        start = 1'b0; dataa = 8'h55; datab = 8'hAA;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dcnt++;
                check_val("ignore_product", {16'd0, product}, 32'h03A8);
            end
        end
        check_val("ignore_done_count", dcnt, 1);
        last_prod = 16'h03A8;

        // Back-to-back with start held high.
        @(negedge clk);
        start = 1'b1; dataa = 8'h0F; datab = 8'h0F;
        @(negedge clk);
        dataa = 8'h10; datab = 8'h10;
        n = 1;
        while (done !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        check_val("b2b_latency", n, 5);
        check_val("b2b_product1", {16'd0, product}, 32'h00E1);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        check_val("b2b_gap", n, 5);
        check_val("b2b_product2", {16'd0, product}, 32'h0100);
        last_prod = 16'h0100;

        // Reset during PP2 aborts.
        @(negedge clk);
        start = 1'b1; dataa = 8'hFF; datab = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_a = 1'b1;
        #1;
        check_val("abort_product", {16'd0, product}, 32'h0);
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        check_val("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset_a = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        check_val("abort_no_done", dcnt, 0);
        check_val("abort_idle_busy", {31'd0, busy}, 32'd0);
        check_val("abort_product_held", {16'd0, product}, 32'h0);
        last_prod = 16'h0000;

        run_mult(8'h03, 8'h07, 16'h0015);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_mult(ra, rb, {8'h00, ra} * {8'h00, rb});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
